// File: rtl/axi_stream_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiters.
package axi_stream_arb_pkg;

  // IDLE arbitrates freely; LOCKED pins the grant until the last beat.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of ptr among n sources.
  function automatic int rr_next(input int ptr, input int n);
    return ((ptr + 1) >= n) ? 0 : (ptr + 1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Equivalent to rotate / priority-encode / unrotate.
module rr_priority_picker #(
  parameter int  N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id
);

  int idx;

  // Walk candidates from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx       = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      gnt_valid = gnt_valid | req[idx];
      gnt_id    = req[idx] ? W'(idx) : gnt_id;
    end
  end

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter with round-robin fairness per packet and a
// single registered output stage (no skid buffer).
module axi_stream_rr_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter int  NUM_SRC    = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int ID_WIDTH   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_SRC-1:0]            s_valid,
  input  logic [NUM_SRC-1:0]            s_last,
  output logic [NUM_SRC-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [ID_WIDTH-1:0]           m_id,
  output logic                          busy
);

  arb_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]     lock_id_q, lock_id_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
  logic                    busy_q, busy_d;

  logic                    pick_valid_s;
  logic [ID_WIDTH-1:0]     pick_id_s;
  logic                    gnt_valid_s;
  logic [ID_WIDTH-1:0]     gnt_id_s;
  logic                    out_en_s;
  logic                    accept_s;
  logic [DATA_WIDTH-1:0]   beat_data_s;
  logic                    beat_last_s;

  rr_priority_picker #(.N(NUM_SRC)) u_picker (
    .req       (s_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (pick_valid_s),
    .gnt_id    (pick_id_s)
  );

  // Grant: free round-robin pick in IDLE, pinned to the packet owner in LOCKED.
  always_comb begin
    gnt_valid_s = pick_valid_s;
    gnt_id_s    = pick_id_s;
    if (state_q == ARB_LOCKED) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = lock_id_q;
    end else begin
      gnt_valid_s = pick_valid_s;
      gnt_id_s    = pick_id_s;
    end
  end

  // Handshake: ready follows output-register space; gated by rst_n so no source
  // sees ready while the arbiter is held in reset.
  always_comb begin
    out_en_s    = !m_valid_q || m_ready;
    beat_data_s = s_data[int'(gnt_id_s)*DATA_WIDTH +: DATA_WIDTH];
    beat_last_s = s_last[gnt_id_s];
    accept_s    = rst_n && out_en_s && gnt_valid_s && s_valid[gnt_id_s];
    s_ready     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_ready[i] = rst_n && out_en_s && gnt_valid_s && (gnt_id_s == ID_WIDTH'(i));
    end
  end

  // Packet-lock FSM and round-robin pointer advance on each packet's last beat.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept_s && beat_last_s) begin
          rr_ptr_d = ID_WIDTH'(rr_next(int'(gnt_id_s), NUM_SRC));
        end else if (accept_s) begin
          state_d   = ARB_LOCKED;
          lock_id_d = gnt_id_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (accept_s && beat_last_s) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ID_WIDTH'(rr_next(int'(lock_id_q), NUM_SRC));
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d == ARB_LOCKED);
  end

  // Output stage: load on accept, drain when consumed with nothing new, else hold.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    if (accept_s) begin
      m_data_d  = beat_data_s;
      m_valid_d = 1'b1;
      m_last_d  = beat_last_s;
      m_id_d    = gnt_id_s;
    end else if (out_en_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
      busy_q    <= busy_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_id    = m_id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Scoreboard bench for axi_stream_rr_arbiter (NUM_SRC=4, DATA_WIDTH=32).
// Expected beats are queued in the hand-worked arbitration order as stimulus
// is issued; a monitor pops and compares on every downstream handshake.
module tb_axi_stream_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0]    s_valid;
  logic [NS-1:0]    s_last;
  logic [NS-1:0]    s_ready;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic [IW-1:0]    m_id;
  logic             busy;

  beat_t            exp_q[$];
  logic [DW:0]      src_q[NS][$];
  logic [NS-1:0]    drv_acc;
  int               n_checks = 0;
  int               n_pass   = 0;

  axi_stream_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .m_id    (m_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  // Queue a beat on a source; if it will reach the output, queue its expectation.
  task automatic send(input int src, input logic [DW-1:0] data, input logic last, input bit expect_out);
    beat_t b;
    src_q[src].push_back({last, data});
    if (expect_out) begin
      b.id   = IW'(src);
      b.data = data;
      b.last = last;
      exp_q.push_back(b);
    end
  endtask

  function automatic bit sources_empty();
    bit e = 1'b1;
    for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((!sources_empty() || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, {63'd0, (n < 100)}, 64'd1);
    check({name, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Source driver: sample handshakes mid-cycle, pop after the edge, present heads.
  initial begin
    logic [DW:0] h;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    forever begin
      @(negedge clk);
      drv_acc = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (drv_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          h = src_q[i][0];
          s_valid[i]         = 1'b1;
          s_data[i*DW +: DW] = h[DW-1:0];
          s_last[i]          = h[DW];
        end else begin
          s_valid[i]         = 1'b0;
          s_data[i*DW +: DW] = '0;
          s_last[i]          = 1'b0;
        end
      end
    end
  end

  // Monitor: each downstream handshake consumes one expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got id=%0d data=%0h last=%0b, expected none", m_id, m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          check("beat", {29'd0, m_id, m_data, m_last}, {29'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            prev_low;
    logic [DW-1:0] prev_data;
    int            n;
    logic          pat [8];
    rst_n   = 1'b0;
    m_ready = 1'b1;

    // Two rounds of single-beat packets on every source: ids 0,1,2,3,0,1,2,3.
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NS; i++)
        send(i, DW'(32'h1000_0000 + 16 * i + j), 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_m_id", {62'd0, m_id}, 64'd0);
    check("rst_s_ready", {60'd0, s_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", {60'd0, s_ready}, 64'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_valid", {63'd0, m_valid}, 64'd1);
      check("rr_id", {62'd0, m_id}, 64'(k % 4));
    end
    drain("rr_drain");

    // rr_ptr=0: src1's 4-beat packet wins, src2 waits until after A3.
    @(posedge clk);
    #2;
    send(1, 32'hA0, 1'b0, 1'b1);
    send(1, 32'hA1, 1'b0, 1'b1);
    send(1, 32'hA2, 1'b0, 1'b1);
    send(1, 32'hA3, 1'b1, 1'b1);
    send(2, 32'hB0, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (src_q[1].size() > 0) check("lock_s_ready2", {63'd0, s_ready[2]}, 64'd0);
      if (src_q[1].size() > 0 && src_q[1].size() < 4) check("lock_busy", {63'd0, busy}, 64'd1);
    end while (src_q[1].size() > 0 && n < 50);
    drain("lock_drain");

    // rr_ptr=3, src3 idle: wrap to src0, then src2.
    @(posedge clk);
    #2;
    send(0, 32'hC0, 1'b0, 1'b1);
    send(0, 32'hC1, 1'b1, 1'b1);
    send(2, 32'hD0, 1'b1, 1'b1);
    drain("wrap_drain");

    // Backpressure on a streaming src0 packet.
    @(posedge clk);
    #2;
    for (int k = 0; k < 5; k++) send(0, DW'(32'hE0 + k), (k == 4), 1'b1);
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    prev_low  = 1'b0;
    prev_data = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 m_ready = pat[k];
      @(negedge clk);
      if (!m_ready && m_valid) check("bp_s_ready", {60'd0, s_ready}, 64'd0);
      if (prev_low && m_valid) check("bp_stable", {32'd0, m_data}, {32'd0, prev_data});
      prev_low  = !m_ready;
      prev_data = m_data;
    end
    m_ready = 1'b1;
    drain("bp_drain");

    // Reset during beat 2 of a src1 packet: only F0 reaches the output.
    @(posedge clk);
    #2;
    send(1, 32'hF0, 1'b0, 1'b1);
    send(1, 32'hF1, 1'b0, 1'b0);
    send(1, 32'hF2, 1'b0, 1'b0);
    send(1, 32'hF3, 1'b1, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (src_q[1].size() > 2 && n < 50);
    check("mid_setup", {63'd0, (n < 50)}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_m_valid", {63'd0, m_valid}, 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_s_ready", {60'd0, s_ready}, 64'd0);
    check("mid_f0_seen", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    send(0, 32'h0000_00C5, 1'b1, 1'b1);
    send(1, 32'h0000_00C6, 1'b1, 1'b1);
    drain("restart_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
